game_controller: RTL and testbench

Top-level game sequencer for the flappy-box datapath. It owns game_en and the obstacle/player clear that drive the obstacle queueing logic. It sequences the round: idle, start countdown, play, hit freeze, game over. It also converts the level-type score_get and collision indications into a 4-digit BCD score and a high score.

---
 rtl/game_pkg.sv | 20 ++
 rtl/game_controller_bcd_counter4.sv | 44 ++++
 rtl/game_controller.sv | 136 +++++++++++++
 tb/tb_game_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state codes and score widths for the game sequencer.
`default_nettype none

package game_pkg;

  localparam int STATE_W    = 3;
  localparam int BCD_DIGITS = 4;
  localparam int SCORE_W    = 16;

  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] READY = 3'd1;
  localparam logic [STATE_W-1:0] PLAY  = 3'd2;
  localparam logic [STATE_W-1:0] HIT   = 3'd3;
  localparam logic [STATE_W-1:0] OVER  = 3'd4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

endpackage

`default_nettype wire

// File: rtl/game_controller_bcd_counter4.sv
// bcd_counter4: 4-digit BCD up-counter with synchronous clear, saturating at 9999.
`default_nettype none

module bcd_counter4
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] value
);

  logic [SCORE_W-1:0]  value_q;
  logic [SCORE_W-1:0]  value_d;
  logic [BCD_DIGITS:0] carry;

  // At 9999 the increment is suppressed entirely so the count never wraps.
  assign carry[0] = inc & (value_q != SCORE_MAX);

  // Ripple a decimal carry through the digits: a 9 rolls to 0 and passes the carry on.
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    logic [3:0] digit;
    assign digit              = value_q[4*i +: 4];
    assign value_d[4*i +: 4]  = carry[i] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
    assign carry[i+1]         = carry[i] & (digit == 4'd9);
  end

  // Score register: clear wins over increment (they never coincide in practice).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else if (clr) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// game_controller: round sequencer (idle/ready/play/hit/over) with BCD score and high score.
`default_nettype none

module game_controller
  import game_pkg::*;
#(
  parameter int START_DELAY = 60,
  parameter int HIT_FREEZE  = 90
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               score_get,
  input  logic               collision,
  output logic               game_en,
  output logic               obj_clear,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] score_bcd,
  output logic [SCORE_W-1:0] hiscore_bcd,
  output logic               new_record
);

  localparam logic [7:0] START_LOAD = 8'(START_DELAY - 1);
  localparam logic [7:0] HIT_LOAD   = 8'(HIT_FREEZE - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               ready_first_q, ready_first_d;
  logic               sg_q;
  logic [SCORE_W-1:0] hiscore_q, hiscore_d;
  logic               new_record_q, new_record_d;
  logic               score_clr;
  logic               score_inc;
  logic [SCORE_W-1:0] score_q;

  bcd_counter4 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score_q)
  );

  // State register plus the round bookkeeping that moves with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      ready_first_q <= 1'b0;
      sg_q          <= 1'b0;
      hiscore_q     <= '0;
      new_record_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      ready_first_q <= ready_first_d;
      sg_q          <= score_get;
      hiscore_q     <= hiscore_d;
      new_record_q  <= new_record_d;
    end
  end

  // Next-state logic; start is handled before frame_tick when leaving IDLE/OVER.
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    ready_first_d = 1'b0;
    hiscore_d     = hiscore_q;
    new_record_d  = new_record_q;
    score_clr     = 1'b0;
    score_inc     = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d       = READY;
          frame_cnt_d   = START_LOAD;
          ready_first_d = 1'b1;
          new_record_d  = 1'b0;
          score_clr     = 1'b1;
        end
      end
      READY: begin
        if (frame_tick) begin
          if (frame_cnt_q == 8'd0) state_d = PLAY;
          else                     frame_cnt_d = frame_cnt_q - 8'd1;
        end
      end
      PLAY: begin
        // A point on the same cycle as a collision is still credited.
        score_inc = score_get & ~sg_q;
        if (collision) begin
          state_d     = HIT;
          frame_cnt_d = HIT_LOAD;
        end
      end
      HIT: begin
        if (frame_tick) begin
          if (frame_cnt_q == 8'd0) begin
            state_d = OVER;
            // Packed BCD orders the same as plain binary, so an unsigned compare suffices.
            if (score_q > hiscore_q) begin
              hiscore_d    = score_q;
              new_record_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state; illegal codes keep the scene held.
  always_comb begin
    game_en   = 1'b0;
    obj_clear = 1'b0;
    case (state_q)
      IDLE:    obj_clear = 1'b1;
      READY:   obj_clear = ready_first_q;
      PLAY:    game_en   = 1'b1;
      HIT:     obj_clear = 1'b0;
      OVER:    obj_clear = 1'b0;
      default: obj_clear = 1'b1;
    endcase
  end

  assign state       = state_q;
  assign score_bcd   = score_q;
  assign hiscore_bcd = hiscore_q;
  assign new_record  = new_record_q;

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// tb_game_controller: directed self-checking bench for game_controller.
`default_nettype none

module tb_game_controller;

  localparam int SD = 3;
  localparam int HF = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        score_get = 1'b0;
  logic        collision = 1'b0;
  logic        game_en;
  logic        obj_clear;
  logic [2:0]  state;
  logic [15:0] score_bcd;
  logic [15:0] hiscore_bcd;
  logic        new_record;

  int n_vec = 0;
  int n_err = 0;

  game_controller #(.START_DELAY(SD), .HIT_FREEZE(HF)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .score_get   (score_get),
    .collision   (collision),
    .game_en     (game_en),
    .obj_clear   (obj_clear),
    .state       (state),
    .score_bcd   (score_bcd),
    .hiscore_bcd (hiscore_bcd),
    .new_record  (new_record)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic press();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic score_edge();
    score_get = 1'b1;
    step();
    score_get = 1'b0;
    step();
  endtask

  task automatic go_play();
    press();
    for (int i = 0; i < SD; i++) tick();
  endtask

  task automatic end_round();
    collision = 1'b1;
    step();
    collision = 1'b0;
    for (int i = 0; i < HF; i++) tick();
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_state", state, 0);
    check("rst_game_en", game_en, 0);
    check("rst_obj_clear", obj_clear, 1);
    check("rst_score", score_bcd, 0);
    check("rst_hiscore", hiscore_bcd, 0);
    check("rst_new_record", new_record, 0);
    reset = 1'b1;
    step();

    // Round 1: countdown timing, obj_clear pulse, start ignored in READY
    press();
    check("r1_ready", state, 1);
    check("r1_clear_pulse", obj_clear, 1);
    step();
    check("r1_clear_drop", obj_clear, 0);
    press();
    check("r1_start_in_ready", state, 1);
    tick(); tick();
    check("r1_not_yet_play", state, 1);
    check("r1_not_yet_en", game_en, 0);
    tick();
    check("r1_play", state, 2);
    check("r1_game_en", game_en, 1);

    // Level score_get counts only rising edges
    score_get = 1'b1;
    for (int i = 0; i < 50; i++) step();
    score_get = 1'b0; step();
    score_get = 1'b1; step();
    score_get = 1'b0; step();
    check("r1_edges_only", score_bcd, 16'h0002);
    press();
    check("r1_start_in_play", state, 2);
    for (int i = 0; i < 10; i++) score_edge();
    check("r1_score12", score_bcd, 16'h0012);
    collision = 1'b1; step(); collision = 1'b0;
    check("r1_hit", state, 3);
    press();
    check("r1_start_in_hit", state, 3);
    for (int i = 0; i < HF - 1; i++) tick();
    check("r1_still_hit", state, 3);
    tick();
    check("r1_over", state, 4);
    check("r1_hiscore", hiscore_bcd, 16'h0012);
    check("r1_new_record", new_record, 1);

    // Round 2: start and frame_tick together, equal score is not a record
    start = 1'b1; frame_tick = 1'b1; step(); start = 1'b0; frame_tick = 1'b0;
    check("r2_ready", state, 1);
    check("r2_score_clr", score_bcd, 0);
    check("r2_nr_clr", new_record, 0);
    check("r2_clear_pulse", obj_clear, 1);
    tick(); tick();
    check("r2_entry_tick_ignored", state, 1);
    tick();
    check("r2_play", state, 2);
    for (int i = 0; i < 12; i++) score_edge();
    end_round();
    check("r2_over", state, 4);
    check("r2_hiscore_same", hiscore_bcd, 16'h0012);
    check("r2_no_record", new_record, 0);

    // Round 3: point and collision on the same clock, ends at 13
    go_play();
    for (int i = 0; i < 12; i++) score_edge();
    score_get = 1'b1; collision = 1'b1; step(); score_get = 1'b0; collision = 1'b0;
    check("r3_credit", score_bcd, 16'h0013);
    check("r3_hit", state, 3);
    check("r3_game_en", game_en, 0);
    for (int i = 0; i < HF; i++) tick();
    check("r3_hiscore", hiscore_bcd, 16'h0013);
    check("r3_record", new_record, 1);

    // Round 4: edge+collision at 7, lower score keeps high score
    go_play();
    for (int i = 0; i < 7; i++) score_edge();
    score_get = 1'b1; collision = 1'b1; step(); score_get = 1'b0; collision = 1'b0;
    check("r4_score8", score_bcd, 16'h0008);
    check("r4_hit", state, 3);
    for (int i = 0; i < HF; i++) tick();
    check("r4_hiscore_kept", hiscore_bcd, 16'h0013);
    check("r4_no_record", new_record, 0);

    // Round 5: decimal carry and saturation
    go_play();
    for (int i = 0; i < 99; i++) score_edge();
    check("r5_99", score_bcd, 16'h0099);
    score_edge();
    check("r5_100", score_bcd, 16'h0100);
    for (int i = 0; i < 9899; i++) score_edge();
    check("r5_9999", score_bcd, 16'h9999);
    score_edge();
    check("r5_saturate", score_bcd, 16'h9999);

    // Asynchronous reset mid-PLAY
    #2 reset = 1'b0;
    #1;
    check("ar_state", state, 0);
    check("ar_game_en", game_en, 0);
    check("ar_obj_clear", obj_clear, 1);
    check("ar_score", score_bcd, 0);
    check("ar_hiscore", hiscore_bcd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
